axis_acc_avg_rep: RTL and testbench
===================================

# axis_acc_avg_rep

Single-input, single-output AXI-Stream processing stage. A compile-time MODE selects one of three functions: block accumulator, power-of-two block averager, or sample repeater. It sits between an upstream AXIS producer and a downstream AXIS consumer, and is full-handshake on both sides.

## Interface
Parameters:
- MODE, 0: function select; 0 = ACC (block sum), 1 = AVG (block mean), 2 = REP (repeater).
- DATA_WIDTH, 6: input sample width.
- ACC_COUNT_LOG, 8: log2 of the block length; block length is ACC_COUNT = 2**ACC_COUNT_LOG (ACC/AVG only).
- IS_SIGNED, 0: 1 means samples are two's complement, so sign-extend and use arithmetic shift; 0 means unsigned.
- NUMBER_OF_REPETITIONS, 7: output copies per input sample (REP only); must be ≥1.
- OUT_WIDTH (localparam): DATA_WIDTH+ACC_COUNT_LOG in ACC mode; DATA_WIDTH otherwise.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous and active-high.
- input_valid  in  1  upstream data valid.
- input_ready  out  1  block accepts a sample.
- input_data  in  DATA_WIDTH  sample.
- output_valid  out  1  result valid.
- output_ready  in  1  downstream accepts.
- output_data  out  OUT_WIDTH  result.

## Operation
- Transfers:
  - Input transfer happens when input_valid && input_ready.
  - Output transfer happens when output_valid && output_ready.
- ACC:
  - Each accepted sample is extended to OUT_WIDTH (sign-extend if IS_SIGNED, zero-extend otherwise) and added to the running sum.
  - A sample counter (ACC_COUNT_LOG bits) wraps at ACC_COUNT.
  - On the ACC_COUNT-th sample, sum + sample is written to the output register, and the running sum and counter clear to 0.
  - The full-precision sum never overflows.
- AVG: same as ACC, except the output is the full sum shifted right by ACC_COUNT_LOG, truncated to DATA_WIDTH.
  - Shift is arithmetic if IS_SIGNED, logical otherwise.
  - This rounds toward −∞ (31.5 → 31, −0.5 → −1).
- REP:
  - An accepted sample is latched and presented NUMBER_OF_REPETITIONS times.
  - A repetition counter advances on each output transfer.
  - After the last copy transfers, the holder empties.
- Reset: output_valid=0, output_data=0, sum=0, counters=0, holder empty. input_ready=1 out of reset in all modes.

## Timing
- ACC/AVG input_ready:
  - High except when the next sample would complete a block while the output register is full and output_ready is low.
  - Non-final samples of a block are always accepted, even while a prior result waits.
- ACC/AVG output latency:
  - output_valid rises the cycle after the final sample's transfer.
  - output_data is held stable until the output transfer.
  - The final sample of block n+1 may be accepted in the same cycle that result n transfers (back-to-back).
- REP input_ready:
  - High when the holder is empty.
  - Also high in the cycle the last copy transfers, which allows zero-bubble streaming.
- REP output:
  - output_valid rises the cycle after the input transfer.
  - Copies go out one per cycle while output_ready is high.
  - With NUMBER_OF_REPETITIONS=1 the block acts as a 1-deep register slice.
- Handshake rules:
  - output_valid never drops without a transfer.
  - output_valid never depends combinationally on output_ready.
  - input_ready may depend combinationally on output_ready.
- Reset mid-operation: a partial block is discarded, a pending output is dropped, and the next accepted sample starts a new block or repetition.
- Stalls of any length on either side cause no loss or duplication.

## Structure
- Package axis_acc_avg_rep_pkg:
  - mode constants MODE_ACC, MODE_AVG, MODE_REP;
  - function out_width(mode, data_width, count_log).
- Sub-module axis_block_summer:
  - contains the counter, extending adder and output register with handshake;
  - shared by ACC and AVG (AVG applies the shift at its output);
  - REP logic lives in the top via a generate branch on MODE.

## Test plan
Stimulus is an incrementing, wrapping generator (0..63, DATA_WIDTH=6, ACC_COUNT_LOG=8). The drain is disabled for the first 10 cycles, then enabled. The generator pauses for 10 cycles mid-run.
- ACC, IS_SIGNED=0: first 256 samples (0..63 ×4) → output_data=8064, valid the cycle after the 256th transfer; the second block also gives 8064.
- AVG, IS_SIGNED=0: same stream → 31. AVG, IS_SIGNED=1 (−32..31 ×4, sum −128) → −1 (6'b111111). ACC, IS_SIGNED=1 → −128.
- REP, N=7: inputs 0,1,2 with drain always ready → output 0×7, 1×7, 2×7 with no bubbles; input_ready high once every 7 cycles.
- Backpressure: with output_ready low for 10 cycles while a result is pending, output_data is held stable, the final sample of the next block is stalled, and no results are lost.
- Reset asserted after 100 samples of a block: output_valid=0 next cycle; the following 256 samples from 0 give ACC=8064.

Source files
------------

// File: rtl/axis_acc_avg_rep_pkg.sv
// Shared definitions for the accumulate / average / repeat AXI-Stream stage.
// Holds the mode encodings, the repeater holder state type and the helper
// that derives the result width from the mode and the block geometry.
package axis_acc_avg_rep_pkg;

    localparam int MODE_ACC = 0;
    localparam int MODE_AVG = 1;
    localparam int MODE_REP = 2;

    typedef enum logic {
        REP_EMPTY = 1'b0,
        REP_FULL  = 1'b1
    } rep_state_e;

    // A block sum needs count_log extra bits so it can never overflow;
    // the mean and the repeated sample keep the input width.
    function automatic int out_width(input int mode, input int data_width, input int count_log);
        if (mode == MODE_ACC) begin
            return data_width + count_log;
        end else begin
            return data_width;
        end
    endfunction

endpackage

// File: rtl/axis_acc_avg_rep_if.sv
// Stream bundle for axis_acc_avg_rep: the upstream (input_*) and the
// downstream (output_*) handshakes of one processing stage.
//   master : the environment side - drives input_valid/input_data and
//            output_ready, observes input_ready/output_valid/output_data.
//   slave  : the processing stage side.
interface axis_acc_avg_rep_if
    import axis_acc_avg_rep_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int OUT_WIDTH  = out_width(MODE_ACC, 6, 8)
);
    logic                  input_valid;
    logic                  input_ready;
    logic [DATA_WIDTH-1:0] input_data;
    logic                  output_valid;
    logic                  output_ready;
    logic [OUT_WIDTH-1:0]  output_data;

    modport master (
        output input_valid, input_data, output_ready,
        input  input_ready, output_valid, output_data
    );

    modport slave (
        input  input_valid, input_data, output_ready,
        output input_ready, output_valid, output_data
    );
endinterface

// File: rtl/axis_acc_avg_rep_summer.sv
// axis_block_summer: sums blocks of 2**COUNT_LOG samples into a full-precision
// result register with a valid/ready handshake on both sides.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   sample handshake, in_data sample
//   out_valid/out_ready result handshake, out_sum block sum
module axis_block_summer #(
    parameter int DATA_WIDTH = 6,
    parameter int COUNT_LOG  = 8,
    parameter int IS_SIGNED  = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH+COUNT_LOG-1:0] out_sum
);
    localparam int SUM_WIDTH = DATA_WIDTH + COUNT_LOG;

    logic [COUNT_LOG-1:0] count_r;
    logic [SUM_WIDTH-1:0] sum_r;
    logic [SUM_WIDTH-1:0] out_sum_r;
    logic                 out_valid_r;
    logic [SUM_WIDTH-1:0] ext_s;
    logic [SUM_WIDTH-1:0] total_s;
    logic                 sign_s;
    logic                 last_s;
    logic                 in_ready_s;
    logic                 in_fire_s;
    logic                 out_fire_s;

    // Sample extension, running total and handshake decode.
    always_comb begin
        sign_s     = (IS_SIGNED != 0) ? in_data[DATA_WIDTH-1] : 1'b0;
        ext_s      = {{COUNT_LOG{sign_s}}, in_data};
        total_s    = sum_r + ext_s;
        last_s     = (count_r == {COUNT_LOG{1'b1}});
        // Only the block-closing sample needs a free result register; a
        // result leaving this very cycle frees it in time.
        in_ready_s = !(last_s && out_valid_r && !out_ready);
        in_fire_s  = in_valid && in_ready_s;
        out_fire_s = out_valid_r && out_ready;
    end

    // Block counter, running sum and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= {COUNT_LOG{1'b0}};
            sum_r       <= {SUM_WIDTH{1'b0}};
            out_sum_r   <= {SUM_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (in_fire_s) begin
                count_r <= count_r + COUNT_LOG'(1);
                if (last_s) begin
                    sum_r     <= {SUM_WIDTH{1'b0}};
                    out_sum_r <= total_s;
                end else begin
                    sum_r <= total_s;
                end
            end
            // A new result has priority: it can only land when the old one
            // has gone or is leaving this cycle.
            if (in_fire_s && last_s) begin
                out_valid_r <= 1'b1;
            end else if (out_fire_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
endmodule

// File: rtl/axis_acc_avg_rep.sv
// axis_acc_avg_rep: AXI-Stream stage selected by MODE - block accumulator,
// power-of-two block averager, or sample repeater.
//   clk  clock
//   rst  synchronous active-high reset
//   bus  stream bundle (slave side): input_valid/input_ready/input_data in,
//        output_valid/output_ready/output_data out
module axis_acc_avg_rep
    import axis_acc_avg_rep_pkg::*;
#(
    parameter int MODE                  = 0,
    parameter int DATA_WIDTH            = 6,
    parameter int ACC_COUNT_LOG         = 8,
    parameter int IS_SIGNED             = 0,
    parameter int NUMBER_OF_REPETITIONS = 7
) (
    input logic               clk,
    input logic               rst,
    axis_acc_avg_rep_if.slave bus
);
    localparam int OUT_WIDTH = out_width(MODE, DATA_WIDTH, ACC_COUNT_LOG);

    if (MODE == MODE_REP) begin : g_rep
        localparam int REP_W = (NUMBER_OF_REPETITIONS > 1) ? $clog2(NUMBER_OF_REPETITIONS) : 1;
        localparam logic [REP_W-1:0] REP_LAST = REP_W'(NUMBER_OF_REPETITIONS - 1);

        rep_state_e            state_r;
        rep_state_e            state_s;
        logic [REP_W-1:0]      rep_cnt_r;
        logic [REP_W-1:0]      rep_cnt_s;
        logic [DATA_WIDTH-1:0] hold_r;
        logic                  last_copy_s;
        logic                  in_ready_s;
        logic                  in_fire_s;
        logic                  out_fire_s;

        // Holder next state; reloading while the last copy leaves gives
        // zero-bubble streaming.
        always_comb begin
            state_s     = state_r;
            rep_cnt_s   = rep_cnt_r;
            last_copy_s = (state_r == REP_FULL) && (rep_cnt_r == REP_LAST);
            in_ready_s  = (state_r == REP_EMPTY) || (last_copy_s && bus.output_ready);
            in_fire_s   = bus.input_valid && in_ready_s;
            out_fire_s  = (state_r == REP_FULL) && bus.output_ready;
            case (state_r)
                REP_EMPTY: begin
                    state_s   = in_fire_s ? REP_FULL : REP_EMPTY;
                    rep_cnt_s = {REP_W{1'b0}};
                end
                REP_FULL: begin
                    if (in_fire_s) begin
                        state_s   = REP_FULL;
                        rep_cnt_s = {REP_W{1'b0}};
                    end else if (out_fire_s && last_copy_s) begin
                        state_s   = REP_EMPTY;
                        rep_cnt_s = {REP_W{1'b0}};
                    end else if (out_fire_s) begin
                        state_s   = REP_FULL;
                        rep_cnt_s = rep_cnt_r + REP_W'(1);
                    end else begin
                        state_s   = REP_FULL;
                        rep_cnt_s = rep_cnt_r;
                    end
                end
                default: begin
                    state_s   = REP_EMPTY;
                    rep_cnt_s = {REP_W{1'b0}};
                end
            endcase
        end

        // Holder state, copy counter and latched sample.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r   <= REP_EMPTY;
                rep_cnt_r <= {REP_W{1'b0}};
                hold_r    <= {DATA_WIDTH{1'b0}};
            end else begin
                state_r   <= state_s;
                rep_cnt_r <= rep_cnt_s;
                if (in_fire_s) begin
                    hold_r <= bus.input_data;
                end
            end
        end

        assign bus.input_ready  = in_ready_s;
        assign bus.output_valid = (state_r == REP_FULL);
        assign bus.output_data  = OUT_WIDTH'(hold_r);
    end else begin : g_blk
        localparam int SUM_WIDTH = DATA_WIDTH + ACC_COUNT_LOG;

        logic [SUM_WIDTH-1:0] sum_s;
        logic                 ready_s;
        logic                 valid_s;

        axis_block_summer #(
            .DATA_WIDTH (DATA_WIDTH),
            .COUNT_LOG  (ACC_COUNT_LOG),
            .IS_SIGNED  (IS_SIGNED)
        ) u_summer (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (bus.input_valid),
            .in_ready  (ready_s),
            .in_data   (bus.input_data),
            .out_valid (valid_s),
            .out_ready (bus.output_ready),
            .out_sum   (sum_s)
        );

        assign bus.input_ready  = ready_s;
        assign bus.output_valid = valid_s;
        // ACC takes the whole sum. AVG takes its top DATA_WIDTH bits, which
        // is the sum shifted right by ACC_COUNT_LOG and truncated; the bits
        // an arithmetic or logical shift would fill in are discarded, so the
        // slice rounds toward minus infinity for both signednesses.
        assign bus.output_data  = sum_s[SUM_WIDTH-1 -: OUT_WIDTH];
    end
endmodule

// File: tb/tb_axis_acc_avg_rep.sv
// Directed bench for axis_acc_avg_rep: four block-mode instances (ACC/AVG,
// unsigned/signed) share one incrementing stream; a REP instance is
// exercised separately.
module tb_axis_acc_avg_rep;
    import axis_acc_avg_rep_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid;
    logic [5:0] in_data;
    logic       out_ready;
    logic       rep_valid;
    logic [5:0] rep_data;
    logic       rep_out_ready;
    logic [5:0] gen;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [13:0] acc_u_q[$];
    logic [13:0] acc_s_q[$];
    logic [5:0]  avg_u_q[$];
    logic [5:0]  avg_s_q[$];
    logic [5:0]  rep_q[$];
    int          rep_out_cyc_q[$];
    int          rep_in_cyc_q[$];

    axis_acc_avg_rep_if #(.DATA_WIDTH(6), .OUT_WIDTH(14)) acc_u_bus ();
    axis_acc_avg_rep_if #(.DATA_WIDTH(6), .OUT_WIDTH(6))  avg_u_bus ();
    axis_acc_avg_rep_if #(.DATA_WIDTH(6), .OUT_WIDTH(6))  avg_s_bus ();
    axis_acc_avg_rep_if #(.DATA_WIDTH(6), .OUT_WIDTH(14)) acc_s_bus ();
    axis_acc_avg_rep_if #(.DATA_WIDTH(6), .OUT_WIDTH(6))  rep_bus ();

    assign acc_u_bus.input_valid  = in_valid;
    assign acc_u_bus.input_data   = in_data;
    assign acc_u_bus.output_ready = out_ready;
    assign avg_u_bus.input_valid  = in_valid;
    assign avg_u_bus.input_data   = in_data;
    assign avg_u_bus.output_ready = out_ready;
    assign avg_s_bus.input_valid  = in_valid;
    assign avg_s_bus.input_data   = in_data;
    assign avg_s_bus.output_ready = out_ready;
    assign acc_s_bus.input_valid  = in_valid;
    assign acc_s_bus.input_data   = in_data;
    assign acc_s_bus.output_ready = out_ready;
    assign rep_bus.input_valid    = rep_valid;
    assign rep_bus.input_data     = rep_data;
    assign rep_bus.output_ready   = rep_out_ready;

    axis_acc_avg_rep #(.MODE(MODE_ACC), .DATA_WIDTH(6), .ACC_COUNT_LOG(8), .IS_SIGNED(0), .NUMBER_OF_REPETITIONS(7))
        u_acc_u (.clk(clk), .rst(rst), .bus(acc_u_bus));
    axis_acc_avg_rep #(.MODE(MODE_AVG), .DATA_WIDTH(6), .ACC_COUNT_LOG(8), .IS_SIGNED(0), .NUMBER_OF_REPETITIONS(7))
        u_avg_u (.clk(clk), .rst(rst), .bus(avg_u_bus));
    axis_acc_avg_rep #(.MODE(MODE_AVG), .DATA_WIDTH(6), .ACC_COUNT_LOG(8), .IS_SIGNED(1), .NUMBER_OF_REPETITIONS(7))
        u_avg_s (.clk(clk), .rst(rst), .bus(avg_s_bus));
    axis_acc_avg_rep #(.MODE(MODE_ACC), .DATA_WIDTH(6), .ACC_COUNT_LOG(8), .IS_SIGNED(1), .NUMBER_OF_REPETITIONS(7))
        u_acc_s (.clk(clk), .rst(rst), .bus(acc_s_bus));
    axis_acc_avg_rep #(.MODE(MODE_REP), .DATA_WIDTH(6), .ACC_COUNT_LOG(8), .IS_SIGNED(0), .NUMBER_OF_REPETITIONS(7))
        u_rep (.clk(clk), .rst(rst), .bus(rep_bus));

    // Record every completed output/input transfer with its cycle number.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (acc_u_bus.output_valid && acc_u_bus.output_ready) acc_u_q.push_back(acc_u_bus.output_data);
        if (avg_u_bus.output_valid && avg_u_bus.output_ready) avg_u_q.push_back(avg_u_bus.output_data);
        if (avg_s_bus.output_valid && avg_s_bus.output_ready) avg_s_q.push_back(avg_s_bus.output_data);
        if (acc_s_bus.output_valid && acc_s_bus.output_ready) acc_s_q.push_back(acc_s_bus.output_data);
        if (rep_bus.output_valid && rep_bus.output_ready) begin
            rep_q.push_back(rep_bus.output_data);
            rep_out_cyc_q.push_back(cyc);
        end
        if (rep_bus.input_valid && rep_bus.input_ready) rep_in_cyc_q.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Sum of 0..63 x4 is 8064 (mean 31); as signed samples the sum is -128
    // (14-bit 16256) and the floored mean is -1 (6-bit 63).
    task automatic check_block(input string tag);
        check_eq({tag, "_valid"}, 32'(acc_u_bus.output_valid), 32'd1);
        check_eq({tag, "_acc_u"}, 32'(acc_u_bus.output_data), 32'd8064);
        check_eq({tag, "_avg_u"}, 32'(avg_u_bus.output_data), 32'd31);
        check_eq({tag, "_avg_s"}, 32'(avg_s_bus.output_data), 32'd63);
        check_eq({tag, "_acc_s"}, 32'(acc_s_bus.output_data), 32'd16256);
    endtask

    // Offer n generator samples, one per cycle when accepted.
    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = gen;
            do begin
                @(posedge clk);
                w++;
            end while (!acc_u_bus.input_ready && w < 50);
            if (!acc_u_bus.input_ready) begin
                check_eq("push_accept", 32'(acc_u_bus.input_ready), 32'd1);
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            gen = gen + 6'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 6'd0; out_ready = 1'b0;
        rep_valid = 1'b0; rep_data = 6'd0; rep_out_ready = 1'b0; gen = 6'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(acc_u_bus.output_valid), 32'd0);
        check_eq("rst_data", 32'(acc_u_bus.output_data), 32'd0);
        check_eq("rst_ready", 32'(acc_u_bus.input_ready), 32'd1);
        check_eq("rst_rep_ready", 32'(rep_bus.input_ready), 32'd1);
        check_eq("rst_rep_valid", 32'(rep_bus.output_valid), 32'd0);
        rst = 1'b0;

        // Block 1: drain held off for 10 cycles, generator pauses mid-block.
        fork
            begin
                repeat (10) @(negedge clk);
                out_ready = 1'b1;
            end
        join_none
        push(100);
        repeat (10) @(negedge clk);
        push(155);
        check_eq("b1_early_valid", 32'(acc_u_bus.output_valid), 32'd0);
        push(1);
        check_block("b1");
        @(negedge clk);
        check_eq("b1_drained", 32'(acc_u_bus.output_valid), 32'd0);

        // Block 2 under backpressure, then block 3 piles up behind it.
        out_ready = 1'b0;
        push(256);
        check_block("b2");
        push(255);
        check_block("b2_hold");
        in_valid = 1'b1;
        in_data  = gen;
        repeat (10) @(negedge clk);
        check_eq("stall_ready", 32'(acc_u_bus.input_ready), 32'd0);
        check_eq("stall_data", 32'(acc_u_bus.output_data), 32'd8064);
        check_eq("stall_count", 32'(acc_u_q.size()), 32'd1);
        out_ready = 1'b1;
        #1;
        check_eq("b2b_ready", 32'(acc_u_bus.input_ready), 32'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        gen       = gen + 6'd1;
        out_ready = 1'b0;
        check_eq("b2b_count", 32'(acc_u_q.size()), 32'd2);
        check_block("b3");

        // Partial block plus pending result are discarded by reset.
        push(100);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(acc_u_bus.output_valid), 32'd0);
        check_eq("mid_rst_data", 32'(acc_u_bus.output_data), 32'd0);
        check_eq("mid_rst_ready", 32'(acc_u_bus.input_ready), 32'd1);
        rst       = 1'b0;
        gen       = 6'd0;
        out_ready = 1'b1;
        push(255);
        check_eq("b4_early_valid", 32'(acc_u_bus.output_valid), 32'd0);
        push(1);
        check_block("b4");
        @(negedge clk);

        check_eq("acc_u_results", 32'(acc_u_q.size()), 32'd3);
        check_eq("avg_u_results", 32'(avg_u_q.size()), 32'd3);
        check_eq("avg_s_results", 32'(avg_s_q.size()), 32'd3);
        check_eq("acc_s_results", 32'(acc_s_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < acc_u_q.size()) check_eq("acc_u_val", 32'(acc_u_q[i]), 32'd8064);
            if (i < avg_u_q.size()) check_eq("avg_u_val", 32'(avg_u_q[i]), 32'd31);
            if (i < avg_s_q.size()) check_eq("avg_s_val", 32'(avg_s_q[i]), 32'd63);
            if (i < acc_s_q.size()) check_eq("acc_s_val", 32'(acc_s_q[i]), 32'd16256);
        end

        // Repeater: 0, 1, 2 offered back to back with the drain always ready.
        rep_out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            int w;
            w = 0;
            @(negedge clk);
            rep_valid = 1'b1;
            rep_data  = 6'(v);
            do begin
                @(posedge clk);
                w++;
            end while (!rep_bus.input_ready && w < 50);
            if (!rep_bus.input_ready) check_eq("rep_accept", 32'(rep_bus.input_ready), 32'd1);
        end
        @(negedge clk);
        rep_valid = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("rep_valid_idle", 32'(rep_bus.output_valid), 32'd0);
        check_eq("rep_out_count", 32'(rep_q.size()), 32'd21);
        check_eq("rep_in_count", 32'(rep_in_cyc_q.size()), 32'd3);
        for (int i = 0; i < 21; i++) begin
            if (i < rep_q.size()) check_eq("rep_val", 32'(rep_q[i]), 32'(i / 7));
        end
        if (rep_q.size() == 21 && rep_in_cyc_q.size() == 3) begin
            check_eq("rep_first_lat", 32'(rep_out_cyc_q[0] - rep_in_cyc_q[0]), 32'd1);
            check_eq("rep_no_bubble", 32'(rep_out_cyc_q[20] - rep_out_cyc_q[0]), 32'd20);
            check_eq("rep_in_gap1", 32'(rep_in_cyc_q[1] - rep_in_cyc_q[0]), 32'd7);
            check_eq("rep_in_gap2", 32'(rep_in_cyc_q[2] - rep_in_cyc_q[1]), 32'd7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
